// File: rtl/multi_byte_adder_pkg.sv
// Shared types and constants for the byte-serial multi-byte adder.
// Holds the FSM state encoding, the slice width and the signed-overflow helper.
package multi_byte_adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow from the operand MSBs, the result MSB and the carry out of the MSB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic cout);
    return a_msb ^ b_msb ^ s_msb ^ cout;
  endfunction

endpackage

// File: rtl/multi_byte_adder_add8.sv
// Combinational 8-bit slice adder, reused for every byte of the serial add.
module add8_stage
  import multi_byte_adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W:0] wide_s;

  // Nine-bit sum so the slice carry-out falls out of the top bit.
  always_comb begin
    wide_s = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    sum    = wide_s[BYTE_W-1:0];
    cout   = wide_s[BYTE_W];
  end

endmodule

// File: rtl/multi_byte_adder.sv
// Byte-serial adder: accepts A, B and cin, adds one byte per cycle LSB first,
// and holds the registered result until the consumer takes it.
module multi_byte_adder
  import multi_byte_adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] in_a,
  input  logic [BYTE_W*NBYTES-1:0] in_b,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               carry_r;
  logic [BYTE_W-1:0]  a_byte_s;
  logic [BYTE_W-1:0]  b_byte_s;
  logic [BYTE_W-1:0]  sum_byte_s;
  logic               cout_s;

  assign in_ready = (state_r == IDLE);

  // Select the captured operand bytes addressed by the current index.
  always_comb begin
    a_byte_s = a_r[int'(idx_r) * BYTE_W +: BYTE_W];
    b_byte_s = b_r[int'(idx_r) * BYTE_W +: BYTE_W];
  end

  add8_stage u_add8 (
    .a    (a_byte_s),
    .b    (b_byte_s),
    .cin  (carry_r),
    .sum  (sum_byte_s),
    .cout (cout_s)
  );

  // Sequencer: capture operands, ripple one byte per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            idx_r   <= '0;
            state_r <= ADD;
          end
        end
        ADD: begin
          out_sum[int'(idx_r) * BYTE_W +: BYTE_W] <= sum_byte_s;
          carry_r <= cout_s;
          // The index parks on the last byte; IDLE clears it for the next operation.
          if (idx_r == LAST_IDX) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            out_cout  <= cout_s;
            out_ovf   <= signed_ovf(a_r[W-1], b_r[W-1], sum_byte_s[BYTE_W-1], cout_s);
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_byte_adder.sv
// Scoreboard bench for multi_byte_adder (NBYTES=4): directed vectors, a held-output
// window, a mid-operation reset, and a random run against a behavioural sum model.
module tb_multi_byte_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  multi_byte_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  logic [33:0] exp_q[$];
  int          acc_q[$];
  bit          rand_ready = 1'b0;
  bit          prev_valid = 1'b0;
  bit          chk_ready_next = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: while a result is presented it must match the queue head; pop on handshake.
  always @(negedge clk) begin
    if (chk_ready_next) begin
      chk("in_ready_after_xfer", {63'd0, in_ready}, 64'd1);
      chk_ready_next = 1'b0;
    end
    if (out_valid && !prev_valid) begin
      if (acc_q.size() == 0) chk("latency_unexpected_valid", 64'd1, 64'd0);
      else chk("latency", 64'(edge_cnt - acc_q.pop_front()), 64'(NB));
    end
    if (out_valid) begin
      chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        chk("result", {30'd0, out_sum, out_cout, out_ovf}, {30'd0, exp_q[0]});
        if (out_ready) begin
          void'(exp_q.pop_front());
          chk_ready_next = 1'b1;
        end
      end
    end
    prev_valid = out_valid;
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s[W-1:0], s[W], v};
  endfunction

  // Present one operand set, record the expectation at the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [33:0] exp);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_q.push_back(edge_cnt + 1);
        exp_q.push_back(exp);
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [33:0] hold_exp;
  logic [W-1:0] ra, rb;
  logic rc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, in_ready, out_valid, out_sum, out_cout, out_ovf}, {29'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed {sum, cout, ovf}
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, {32'h0000_0100, 1'b0, 1'b0}); drain();
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {32'h0000_0000, 1'b1, 1'b0}); drain();
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 1'b0, 1'b1}); drain();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 1'b1, 1'b1}); drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'hFFFF_FFFF, 1'b1, 1'b0}); drain();

    // Held result: no consumer for 5 cycles while inputs toggle
    out_ready = 1'b0;
    hold_exp = {32'h2345_678A, 1'b0, 1'b0};
    issue(32'h1234_5678, 32'h1111_1111, 1'b1, hold_exp);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk("hold_valid_seen", {63'd0, out_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid; in_a = $urandom; in_b = $urandom; in_cin = ~in_cin;
      @(negedge clk);
      chk("hold_outputs", {29'd0, out_valid, in_ready, out_sum, out_cout, out_ovf}, {29'd0, 1'b1, 1'b0, hold_exp});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while the adder is on byte index 2: the operation must vanish
    in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_reset_state", {29'd0, in_ready, out_valid, out_sum, out_cout, out_ovf}, {29'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0});
    for (int k = 0; k < NB + 4; k++) begin
      @(negedge clk);
      chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // Random operands with random back-pressure against the behavioural model
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if (i % 7 == 0) ra = 32'h7FFF_FFFF;
      if (i % 11 == 0) rb = 32'h8000_0000;
      issue(ra, rb, rc, model(ra, rb, rc));
    end
    drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (NB + 4) @(posedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
